spi_command_controller: RTL and testbench

Command sequencer between the SPI secondary and the motion-segment FIFO. It decodes the first byte of each chip-select frame, answers status queries, and assembles incoming bytes into whole `RecordWords`-byte motion segments in a staging buffer. Only complete segments are burst-committed into the byte FIFO, so a frame aborted by chip-select never leaves a partial segment in front of the step generator. It replaces the ad-hoc command FSM at top level.

---
 rtl/spi_command_controller_if.sv | 31 +++
 rtl/spi_command_controller.sv | 141 ++++++++++++++
 tb/tb_spi_command_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_command_controller_if.sv
// rtl/spi_command_controller_if.sv - SPI-side and FIFO-side signal bundle for the command sequencer.
// master drives the SPI secondary and FIFO fill inputs; slave is the sequencer.
interface spi_command_controller_if #(
  parameter int RecordWords = 4,
  parameter int FifoDepth   = 16
);
  localparam int SizeW = $clog2(FifoDepth * RecordWords) + 1;

  logic             spi_cs;
  logic             word_ready;
  logic [7:0]       data_word_received;
  logic [7:0]       data_word_to_send;
  logic [SizeW-1:0] fifo_size;
  logic             fifo_write_en;
  logic [7:0]       fifo_data_in;
  logic             commit_busy;
  logic [3:0]       status_flags;
  logic [15:0]      records_committed;

  modport master (
    output spi_cs, word_ready, data_word_received, fifo_size,
    input  data_word_to_send, fifo_write_en, fifo_data_in, commit_busy,
           status_flags, records_committed
  );

  modport slave (
    input  spi_cs, word_ready, data_word_received, fifo_size,
    output data_word_to_send, fifo_write_en, fifo_data_in, commit_busy,
           status_flags, records_committed
  );
endinterface

// File: rtl/spi_command_controller.sv
// rtl/spi_command_controller.sv - Frame decoder that stages motion segments and burst-commits whole ones to the FIFO.
// A segment reaches the FIFO only once all of its bytes have arrived, so aborted frames never leave fragments.
module spi_command_controller #(
  parameter int RecordWords = 4,
  parameter int FifoDepth   = 16
) (
  input logic                      clk,
  input logic                      reset,
  spi_command_controller_if.slave  bus
);
  localparam int IdxW  = $clog2(RecordWords);
  localparam int CntW  = IdxW + 1;
  localparam int SizeW = $clog2(FifoDepth * RecordWords) + 1;
  localparam logic [SizeW:0]    DepthW = (SizeW + 1)'(FifoDepth);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(RecordWords - 1);
  localparam logic [CntW-1:0]   FullCnt = CntW'(RecordWords);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STATUS  = 2'd1,
    RECEIVE = 2'd2
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] collect_idx_q;
  logic [7:0]      stage_q [RecordWords];
  logic [7:0]      cbuf_q  [RecordWords];
  logic [CntW-1:0] wcnt_q;
  logic            busy_q;
  logic            we_q;
  logic [7:0]      din_q;
  logic [3:0]      flags_q;
  logic [15:0]     committed_q;

  logic            accepted;
  logic            rec_done;
  logic            start_burst;
  logic            flag_clr;
  logic [3:0]      flag_set;
  logic [3:0]      flags_d;
  logic [SizeW-1:0] seg_used;
  logic [SizeW:0]  used;
  logic [7:0]      free_slots;
  logic [7:0]      to_send;

  // The segment being burst out still occupies a slot until it lands in the FIFO.
  always_comb begin
    seg_used = bus.fifo_size >> IdxW;
    used     = {1'b0, seg_used} + {{SizeW{1'b0}}, busy_q};
    if (used >= DepthW) free_slots = 8'd0;
    else                free_slots = 8'(DepthW - used);
  end

  always_comb begin
    accepted    = bus.word_ready && !bus.spi_cs;
    rec_done    = accepted && (state_q == RECEIVE) && (collect_idx_q == LastIdx);
    start_burst = rec_done && !busy_q && (free_slots != 8'd0);
    flag_clr    = accepted && (state_q == STATUS);
    flag_set    = 4'b0000;
    flag_set[0] = rec_done && busy_q;
    flag_set[1] = rec_done && !busy_q && (free_slots == 8'd0);
    flag_set[2] = bus.spi_cs && (state_q == RECEIVE) && (collect_idx_q != '0);
    flag_set[3] = accepted && (state_q == IDLE) && (bus.data_word_received > 8'd2);
    flags_d     = (flag_clr ? 4'b0000 : flags_q) | flag_set;
  end

  always_comb begin
    to_send = 8'd0;
    case (state_q)
      IDLE:    to_send = free_slots;
      STATUS:  to_send = {4'b0000, flags_q};
      default: to_send = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      collect_idx_q <= '0;
      wcnt_q        <= '0;
      busy_q        <= 1'b0;
      we_q          <= 1'b0;
      din_q         <= 8'd0;
      flags_q       <= 4'b0000;
      committed_q   <= 16'd0;
      for (int i = 0; i < RecordWords; i++) begin
        stage_q[i] <= 8'd0;
        cbuf_q[i]  <= 8'd0;
      end
    end else begin
      flags_q <= flags_d;

      if (bus.spi_cs) begin
        state_q       <= IDLE;
        collect_idx_q <= '0;
      end else if (accepted) begin
        case (state_q)
          IDLE: begin
            case (bus.data_word_received)
              8'd1:    state_q <= STATUS;
              8'd2:    state_q <= RECEIVE;
              default: state_q <= IDLE;
            endcase
          end
          RECEIVE: begin
            stage_q[collect_idx_q] <= bus.data_word_received;
            collect_idx_q          <= collect_idx_q + IdxW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end

      // Burst engine runs independently of chip-select so a started segment always completes.
      if (start_burst) begin
        for (int i = 0; i < RecordWords; i++) begin
          cbuf_q[i] <= (i == RecordWords - 1) ? bus.data_word_received : stage_q[i];
        end
        busy_q <= 1'b1;
        we_q   <= 1'b1;
        din_q  <= stage_q[0];
        wcnt_q <= CntW'(1);
      end else if (busy_q) begin
        if (wcnt_q == FullCnt) begin
          busy_q      <= 1'b0;
          we_q        <= 1'b0;
          committed_q <= committed_q + 16'd1;
        end else begin
          din_q  <= cbuf_q[wcnt_q[IdxW-1:0]];
          wcnt_q <= wcnt_q + CntW'(1);
        end
      end
    end
  end

  assign bus.data_word_to_send = to_send;
  assign bus.fifo_write_en     = we_q;
  assign bus.fifo_data_in      = din_q;
  assign bus.commit_busy       = busy_q;
  assign bus.status_flags      = flags_q;
  assign bus.records_committed = committed_q;
endmodule

// File: tb/tb_spi_command_controller.sv
// tb/tb_spi_command_controller.sv - Directed vector bench for the SPI command sequencer.
module tb_spi_command_controller;
  localparam int RW = 4;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_command_controller_if #(.RecordWords(RW), .FifoDepth(FD)) bus ();

  spi_command_controller #(.RecordWords(RW), .FifoDepth(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int fill_base = 0;
  int wr_cnt;
  logic [7:0] wlog [64];
  int checks = 0;
  int errors = 0;

  assign bus.fifo_size = 7'(fill_base + wr_cnt);

  always @(posedge clk or posedge reset) begin
    if (reset) wr_cnt <= 0;
    else if (bus.fifo_write_en) begin
      if (wr_cnt < 64) wlog[wr_cnt] <= bus.fifo_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        cs;
    logic        wr;
    logic [7:0]  d;
    logic [7:0]  send;
    logic [3:0]  flags;
    logic [15:0] comm;
    logic        we;
    logic [7:0]  din;
    logic        busy;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic wr, input logic [7:0] d);
    @(negedge clk);
    bus.spi_cs = cs;
    bus.word_ready = wr;
    bus.data_word_received = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [7:0] d);
    drive(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.spi_cs = 1'b1;
    bus.word_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.spi_cs = 1'b1;
    bus.word_ready = 1'b0;
    bus.data_word_received = 8'h00;

    //            cs  wr  d       send   flags comm  we  din    busy
    vecs[0]  = '{1'b0, 1'b1, 8'h02, 8'd0,  4'h0, 16'd0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA1, 8'd0,  4'h0, 16'd0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hB2, 8'd0,  4'h0, 16'd0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hC3, 8'd0,  4'h0, 16'd0, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hD4, 8'd0,  4'h0, 16'd0, 1'b1, 8'hA1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'd0,  4'h0, 16'd0, 1'b1, 8'hB2, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'd0,  4'h0, 16'd0, 1'b1, 8'hC3, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'd0,  4'h0, 16'd0, 1'b1, 8'hD4, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'd15, 4'h0, 16'd1, 1'b0, 8'hD4, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h07, 8'd15, 4'h8, 16'd1, 1'b0, 8'hD4, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'd15, 4'h8, 16'd1, 1'b0, 8'hD4, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h01, 8'd8,  4'h8, 16'd1, 1'b0, 8'hD4, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h55, 8'd15, 4'h0, 16'd1, 1'b0, 8'hD4, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h02, 8'd15, 4'h0, 16'd1, 1'b0, 8'hD4, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst send", 16'(bus.data_word_to_send), 16'd16);
    check("rst we", 16'(bus.fifo_write_en), 16'd0);
    check("rst din", 16'(bus.fifo_data_in), 16'd0);
    check("rst busy", 16'(bus.commit_busy), 16'd0);
    check("rst flags", 16'(bus.status_flags), 16'd0);
    check("rst comm", bus.records_committed, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cs, vecs[i].wr, vecs[i].d);
      check($sformatf("v%0d send", i), 16'(bus.data_word_to_send), 16'(vecs[i].send));
      check($sformatf("v%0d flags", i), 16'(bus.status_flags), 16'(vecs[i].flags));
      check($sformatf("v%0d comm", i), bus.records_committed, vecs[i].comm);
      check($sformatf("v%0d we", i), 16'(bus.fifo_write_en), 16'(vecs[i].we));
      check($sformatf("v%0d din", i), 16'(bus.fifo_data_in), 16'(vecs[i].din));
      check($sformatf("v%0d busy", i), 16'(bus.commit_busy), 16'(vecs[i].busy));
    end
    check("log0", 16'(wlog[0]), 16'h00A1);
    check("log1", 16'(wlog[1]), 16'h00B2);
    check("log2", 16'(wlog[2]), 16'h00C3);
    check("log3", 16'(wlog[3]), 16'h00D4);
    check("wr cnt 1", 16'(wr_cnt), 16'd4);

    // Aborted frame: three bytes then deselect.
    step(8'h02); step(8'h11); step(8'h22); step(8'h33);
    drive(1'b1, 1'b0, 8'h00);
    check("partial flags", 16'(bus.status_flags), 16'h0004);
    idle(6);
    check("partial no wr", 16'(wr_cnt), 16'd4);
    step(8'h01);
    check("status send", 16'(bus.data_word_to_send), 16'h0004);
    step(8'h99);
    check("status clr", 16'(bus.status_flags), 16'h0000);
    check("status idle send", 16'(bus.data_word_to_send), 16'd15);
    drive(1'b1, 1'b0, 8'h00);

    // FIFO full: record dropped.
    pulse_reset();
    fill_base = 64;
    drive(1'b1, 1'b0, 8'h00);
    check("full send", 16'(bus.data_word_to_send), 16'd0);
    step(8'h02); step(8'h01); step(8'h02); step(8'h03); step(8'h04);
    idle(5);
    check("full no wr", 16'(wr_cnt), 16'd0);
    check("full flags", 16'(bus.status_flags), 16'h0002);
    check("full comm", bus.records_committed, 16'd0);
    drive(1'b1, 1'b0, 8'h00);

    // Back-to-back records: second completes while the first is still bursting.
    pulse_reset();
    fill_base = 0;
    drive(1'b1, 1'b0, 8'h00);
    step(8'h02);
    step(8'h10); step(8'h11); step(8'h12); step(8'h13);
    step(8'h20); step(8'h21); step(8'h22); step(8'h23);
    idle(6);
    check("ovr comm", bus.records_committed, 16'd1);
    check("ovr flags", 16'(bus.status_flags), 16'h0001);
    check("ovr wr", 16'(wr_cnt), 16'd4);
    check("ovr log3", 16'(wlog[3]), 16'h0013);
    drive(1'b1, 1'b0, 8'h00);
    step(8'h01); step(8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("ovr clr", 16'(bus.status_flags), 16'h0000);

    // Second record lands one cycle after the burst ends: accepted.
    step(8'h02);
    step(8'h30); step(8'h31); step(8'h32); step(8'h33);
    step(8'h40); step(8'h41); step(8'h42);
    idle(1);
    step(8'h43);
    idle(6);
    check("edge comm", bus.records_committed, 16'd3);
    check("edge flags", 16'(bus.status_flags), 16'h0000);
    check("edge wr", 16'(wr_cnt), 16'd12);
    check("edge log4", 16'(wlog[4]), 16'h0030);
    check("edge log8", 16'(wlog[8]), 16'h0040);
    check("edge log11", 16'(wlog[11]), 16'h0043);
    drive(1'b1, 1'b0, 8'h00);
    check("edge send", 16'(bus.data_word_to_send), 16'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
